// File: rtl/dff_pipe.sv
// dff_pipe: valid/ready register pipeline with bubble collapse,
// flush and beat occupancy counter.
module dff_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           in_valid,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           in_ready,
  output logic                           out_valid,
  output logic [WIDTH-1:0]               out_data,
  input  logic                           out_ready,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [DEPTH-1:0] free;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             in_hs;
  logic             out_hs;

  // A stage is free if it, or any stage after it, is empty or the
  // output is being drained; accumulate from the tail toward the head.
  always_comb begin
    logic acc;
    acc = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc     = acc | ~vld_q[i];
      free[i] = acc;
    end
  end

  assign in_ready  = free[0] & ~flush & ~reset;
  assign in_hs     = in_valid & in_ready;
  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign out_hs    = out_valid & out_ready;
  assign count     = count_q;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (free[0]) begin
      vld_d[0] = in_hs;
      if (in_hs) begin
        data_d[0] = in_data;
      end
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (free[i]) begin
        vld_d[i] = vld_q[i-1];
        if (vld_q[i-1]) begin
          data_d[i] = data_q[i-1];
        end
      end
    end
    // Flush drops every beat but leaves payload registers untouched.
    if (flush) begin
      vld_d  = '0;
      data_d = data_q;
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (in_hs && !out_hs) begin
      count_d = count_q + CW'(1);
    end else if (out_hs && !in_hs) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VALUE;
      end
    end else begin
      vld_q   <= vld_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

endmodule
